// File: rtl/audio_pkg.sv
// Shared defaults for the audio sample pacer and its FIFO.
// MIDSCALE is the sample value that leaves a signed DAC at zero output.
package audio_pkg;

    localparam int SAMPLE_BITS_DEFAULT = 12;
    localparam int DEPTH_LOG2_DEFAULT  = 4;
    localparam int DIV_BITS_DEFAULT    = 16;
    localparam int MIDSCALE            = 0;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock synchronous FIFO with an occupancy output.
// Pushes while full and pops while empty are ignored.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH      = SAMPLE_BITS_DEFAULT,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push;
    logic                  pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly DEPTH_LOG2 bits wide, so they wrap modulo depth.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_pacer.sv
// Buffers producer samples and releases one to the DAC every rate_div+1
// enabled clocks; an empty FIFO at release time emits midscale and flags underrun.
module audio_sample_pacer
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEFAULT,
    parameter int DEPTH_LOG2  = DEPTH_LOG2_DEFAULT,
    parameter int DIV_BITS    = DIV_BITS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [SAMPLE_BITS-1:0] wr_data,
    input  logic                   enable,
    input  logic [DIV_BITS-1:0]    rate_div,
    input  logic                   underrun_clr,
    output logic [SAMPLE_BITS-1:0] dout,
    output logic                   sample_tick,
    output logic [DEPTH_LOG2:0]    level,
    output logic                   underrun
);

    // Write handshake: a sample transfers on any rising edge where
    // wr_valid && wr_ready; wr_ready is "not full" and ignores a same-cycle pop.
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [SAMPLE_BITS-1:0] head;
    logic [DIV_BITS-1:0]    period_cnt;
    logic                   tick;

    assign tick     = enable && (period_cnt == '0);
    assign wr_ready = !fifo_full;

    sample_fifo #(
        .WIDTH      (SAMPLE_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_valid),
        .wr_data (wr_data),
        .rd_en   (tick),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Counter resets to 0 so the first enabled cycle after reset releases a sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_cnt  <= '0;
            dout        <= '0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sample_tick <= tick;
            if (!enable || period_cnt == '0) begin
                period_cnt <= rate_div;
            end else begin
                period_cnt <= period_cnt - 1'b1;
            end
            if (tick) begin
                dout <= fifo_empty ? SAMPLE_BITS'(MIDSCALE) : head;
            end
            // A fresh underrun wins over a coincident clear.
            underrun <= (underrun && !underrun_clr) || (tick && fifo_empty);
        end
    end

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer: a per-cycle vector table for steady
// playback, then hand-written sequences for full/empty, rate change and reset.
module tb_audio_sample_pacer;

    localparam int SB = 12;
    localparam int DL = 4;
    localparam int DB = 16;

    logic          clk;
    logic          resetn;
    logic          wr_valid;
    logic          wr_ready;
    logic [SB-1:0] wr_data;
    logic          enable;
    logic [DB-1:0] rate_div;
    logic          underrun_clr;
    logic [SB-1:0] dout;
    logic          sample_tick;
    logic [DL:0]   level;
    logic          underrun;

    int n_checks;
    int n_errors;

    audio_sample_pacer #(
        .SAMPLE_BITS (SB),
        .DEPTH_LOG2  (DL),
        .DIV_BITS    (DB)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .enable       (enable),
        .rate_div     (rate_div),
        .underrun_clr (underrun_clr),
        .dout         (dout),
        .sample_tick  (sample_tick),
        .level        (level),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic wr_valid;
        int   wr_data;
        logic enable;
        int   exp_dout;
        logic exp_tick;
        int   exp_level;
        logic exp_underrun;
        logic exp_ready;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        wr_valid     = 1'b0;
        wr_data      = '0;
        enable       = 1'b0;
        underrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic write_one(input int val);
        wr_valid = 1'b1;
        wr_data  = SB'(val);
        step();
        wr_valid = 1'b0;
    endtask

    // Counts edges until sample_tick is seen, giving up after a bounded budget.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_tick && n < 64);
    endtask

    int samp[16];
    int n;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rate_div = DB'(3);

        // Reset state
        resetn       = 1'b0;
        wr_valid     = 1'b0;
        wr_data      = '0;
        enable       = 1'b0;
        underrun_clr = 1'b0;
        @(negedge clk);
        check("reset_dout", $signed(dout), 0);
        check("reset_tick", sample_tick, 0);
        check("reset_level", level, 0);
        check("reset_underrun", underrun, 0);
        check("reset_ready", wr_ready, 1);
        @(negedge clk);
        resetn = 1'b1;

        // Steady playback at rate_div=3: rows hold inputs for one clock,
        // expectations are the outputs right after that clock edge.
        vecs[0]  = '{1'b1, 100,  1'b0, 0,    1'b0, 1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, -5,   1'b0, 0,    1'b0, 2, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 2047, 1'b0, 0,    1'b0, 3, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 0,    1'b1, 0,    1'b0, 3, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 0,    1'b1, 0,    1'b0, 3, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 0,    1'b1, 0,    1'b0, 3, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 0,    1'b1, 100,  1'b1, 2, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 0,    1'b1, 100,  1'b0, 2, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 0,    1'b1, 100,  1'b0, 2, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 0,    1'b1, 100,  1'b0, 2, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 0,    1'b1, -5,   1'b1, 1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 0,    1'b1, -5,   1'b0, 1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 0,    1'b1, -5,   1'b0, 1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 0,    1'b1, -5,   1'b0, 1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 0,    1'b1, 2047, 1'b1, 0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 0,    1'b1, 2047, 1'b0, 0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 0,    1'b1, 2047, 1'b0, 0, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 0,    1'b1, 2047, 1'b0, 0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 0,    1'b1, 0,    1'b1, 0, 1'b1, 1'b1};

        for (int i = 0; i < 19; i++) begin
            wr_valid = vecs[i].wr_valid;
            wr_data  = SB'(vecs[i].wr_data);
            enable   = vecs[i].enable;
            step();
            check($sformatf("vec%0d_dout", i), $signed(dout), vecs[i].exp_dout);
            check($sformatf("vec%0d_tick", i), sample_tick, vecs[i].exp_tick);
            check($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
            check($sformatf("vec%0d_underrun", i), underrun, vecs[i].exp_underrun);
            check($sformatf("vec%0d_ready", i), wr_ready, vecs[i].exp_ready);
        end
        wr_valid = 1'b0;

        // Fill to 16 while disabled, overflow write, then drain at rate_div=0
        do_reset();
        rate_div = DB'(0);
        for (int i = 0; i < 16; i++) begin
            samp[i] = i * 250 - 2000;
            write_one(samp[i]);
        end
        check("full_level", level, 16);
        check("full_ready", wr_ready, 0);
        write_one(999);
        check("overflow_level", level, 16);

        // Write and tick in the same cycle while full: write refused
        wr_valid = 1'b1;
        wr_data  = SB'(555);
        enable   = 1'b1;
        step();
        wr_valid = 1'b0;
        check("full_tick_level", level, 15);
        check("full_tick_dout", $signed(dout), samp[0]);
        check("full_tick_pulse", sample_tick, 1);
        for (int i = 1; i < 16; i++) begin
            step();
            check($sformatf("drain%0d_dout", i), $signed(dout), samp[i]);
            check($sformatf("drain%0d_level", i), level, 15 - i);
        end
        check("drain_underrun", underrun, 0);

        // Empty FIFO at rate_div=0: midscale every cycle, sticky underrun
        step();
        check("empty_dout", $signed(dout), 0);
        check("empty_underrun", underrun, 1);
        step();
        check("empty2_tick", sample_tick, 1);
        check("empty2_dout", $signed(dout), 0);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check("clr_vs_new_underrun", underrun, 1);

        // Clear without a tick, then write and tick together on empty
        enable       = 1'b0;
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check("clr_underrun", underrun, 0);
        check("disabled_tick", sample_tick, 0);
        enable   = 1'b1;
        wr_valid = 1'b1;
        wr_data  = SB'(321);
        step();
        wr_valid = 1'b0;
        check("wr_tick_empty_underrun", underrun, 1);
        check("wr_tick_empty_dout", $signed(dout), 0);
        check("wr_tick_empty_level", level, 1);
        step();
        check("wr_tick_empty_next_dout", $signed(dout), 321);
        check("wr_tick_empty_next_level", level, 0);

        // rate_div change mid-period takes effect at the next reload
        do_reset();
        rate_div = DB'(3);
        write_one(10);
        write_one(20);
        write_one(30);
        write_one(40);
        enable = 1'b1;
        wait_tick(n);
        check("rate_first_gap", n, 4);
        check("rate_first_dout", $signed(dout), 10);
        rate_div = DB'(7);
        wait_tick(n);
        check("rate_old_gap", n, 4);
        check("rate_old_dout", $signed(dout), 20);
        wait_tick(n);
        check("rate_new_gap", n, 8);
        check("rate_new_dout", $signed(dout), 30);

        // Reset mid-stream with level=5
        do_reset();
        rate_div = DB'(3);
        for (int i = 1; i <= 6; i++) write_one(i * 11);
        enable = 1'b1;
        wait_tick(n);
        check("mid_gap", n, 4);
        check("mid_dout", $signed(dout), 11);
        check("mid_level", level, 5);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("async_level", level, 0);
        check("async_dout", $signed(dout), 0);
        check("async_underrun", underrun, 0);
        check("async_tick", sample_tick, 0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("post_reset_tick", sample_tick, 1);
        check("post_reset_dout", $signed(dout), 0);
        check("post_reset_underrun", underrun, 1);
        check("post_reset_level", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
